// File: rtl/mux7_rr_arbiter.sv
// mux7_rr_arbiter
//   Round-robin arbiter that shares one 7:1 mux between seven requesters.
//   Only one requester is granted at a time. The 3-bit select steers the
//   granted lane onto the shared output. A hold limit keeps a lane that
//   never drops its request from starving the others.
//
// Ports
//   clock    : system clock, rising edge
//   resetn   : synchronous, active-low reset
//   req      : [6:0] request per lane, bit i = requester i
//   grant    : [6:0] registered one-hot grant, zero while idle
//   sel      : [2:0] registered mux select (index of granted lane, 0..6)
//   busy     : high while a grant is active
//   hold_cnt : [HOLD_W-1:0] cycles the current grant has been held (saturating)
//   state    : FSM state for observation (0 = IDLE, 1 = GRANT)
//
// Handshake: a requester raises req[i] and holds it until grant[i] is seen.
// The grant lasts while req[i] stays high, unless another lane is waiting
// and the hold limit has been reached. Dropping req[i] releases the grant
// at the next edge. Every release is followed by exactly one IDLE cycle,
// and arbitration happens in that cycle.
module mux7_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [6:0]        req,
    output logic [6:0]        grant,
    output logic [2:0]        sel,
    output logic              busy,
    output logic [HOLD_W-1:0] hold_cnt,
    output logic              state
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);

    state_t            state_q, state_n;
    logic [6:0]        grant_n;
    logic [2:0]        sel_n;
    logic [HOLD_W-1:0] hold_n;
    logic [2:0]        last_q, last_n;

    // Rotating priority search: the first set request, starting at lane
    // last+1 and wrapping from 6 back to 0.
    logic [2:0] winner;
    logic       found;
    logic [3:0] sum;
    logic [2:0] lane;

    always_comb begin
        winner = 3'd0;
        found  = 1'b0;
        sum    = 4'd0;
        lane   = 3'd0;
        for (int k = 1; k <= 7; k++) begin
            sum  = {1'b0, last_q} + 4'(k);
            lane = (sum >= 4'd7) ? 3'(sum - 4'd7) : sum[2:0];
            if (!found && req[lane]) begin
                winner = lane;
                found  = 1'b1;
            end
        end
    end

    // Requests from lanes other than the current grantee.
    logic [6:0] others;
    logic       preempt;
    logic       release_now;

    always_comb begin
        others      = req & ~(7'b1 << sel);
        preempt     = (MAX_HOLD != 0) && (hold_cnt >= HOLD_LIMIT)
                      && req[sel] && (others != 7'd0);
        release_now = !req[sel] || preempt;
    end

    always_comb begin
        state_n = state_q;
        grant_n = grant;
        sel_n   = sel;
        hold_n  = hold_cnt;
        last_n  = last_q;
        unique case (state_q)
            IDLE: begin
                grant_n = 7'd0;
                if (found) begin
                    grant_n = 7'b1 << winner;
                    sel_n   = winner;
                    hold_n  = HOLD_W'(1);
                    state_n = GRANT;
                end
            end
            GRANT: begin
                if (release_now) begin
                    grant_n = 7'd0;
                    hold_n  = '0;
                    last_n  = sel;
                    state_n = IDLE;
                end else if (!(&hold_cnt)) begin
                    hold_n = hold_cnt + HOLD_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q  <= IDLE;
            grant    <= 7'd0;
            sel      <= 3'd0;
            hold_cnt <= '0;
            last_q   <= 3'd6;   // lane 0 wins first after reset
        end else begin
            state_q  <= state_n;
            grant    <= grant_n;
            sel      <= sel_n;
            hold_cnt <= hold_n;
            last_q   <= last_n;
        end
    end

    assign busy  = (state_q == GRANT);
    assign state = state_q;

endmodule

// File: doc/mux7_rr_arbiter.md
Name: mux7_rr_arbiter

Overview:
- Round-robin arbiter sharing one 7:1 mux between 7 requesters.
- Grants exactly one requester at a time.
- Drives the 3-bit mux select so the granted requester's lane reaches the shared output.
- Enforces a maximum hold time, so a requester that holds its request cannot starve the others.

Parameters:
- MAX_HOLD, 8, maximum GRANT cycles before forced release when others are waiting; 0 disables preemption.
- HOLD_W, 4, width of the hold counter; must satisfy MAX_HOLD < 2^HOLD_W.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- resetn  input  1  synchronous, active-low reset.
- req  input  7  request per lane; bit i = requester i.
- grant  output  7  one-hot grant, registered; all zero when idle.
- sel  output  3  mux select = index of the granted lane, registered; range 0..6 only.
- busy  output  1  high while any grant is active.
- hold_cnt  output  HOLD_W  cycles the current grant has been held, saturating.

Behaviour:
- Reset: while resetn=0 at a clock edge, all state is cleared and outputs take these values:
  - grant=0, sel=0, busy=0, hold_cnt=0, state=IDLE.
  - last=6, so requester 0 has top priority after reset.
- Reset is synchronous: a reset asserted mid-grant clears the grant at that edge with no partial release.
- Two states, IDLE and GRANT.
- IDLE, when req != 0:
  - Winner is the first set bit of req, searching from (last+1) mod 7 upward with wrap 6->0.
  - At the next edge: grant = one-hot(winner), sel = winner, busy=1, hold_cnt=1, state goes to GRANT.
  - Latency from request to grant is 1 cycle.
- IDLE, when req = 0: stay in IDLE; outputs unchanged except grant=0 and busy=0; sel keeps its previous value.
- GRANT:
  - Current lane cur = sel.
  - hold_cnt increments each cycle and saturates at 2^HOLD_W-1.
  - Release, when req[cur]=0 at an edge: grant=0, busy=0, hold_cnt=0, last=cur, state goes to IDLE.
  - Preempt, when MAX_HOLD != 0, hold_cnt >= MAX_HOLD, req[cur]=1 and (req with bit cur cleared) != 0: same action as release.
  - Otherwise the grant is held. If cur is the only requester, it holds indefinitely past MAX_HOLD.
- Gap between grants: exactly one IDLE cycle after every release or preempt, in which arbitration occurs. Back-to-back grants to different lanes are therefore at least 1 cycle apart.
- Requests that rise and fall within a GRANT period of another lane are not remembered.
- Requesters must hold req until granted.
- last updates only on release or preempt, never on grant.
- Simultaneous events:
  - Release and a new request arriving in the same cycle: release wins; the new request is arbitrated in the following IDLE cycle.
  - Preempt and release in the same cycle are equivalent.
- Invariants:
  - grant has at most one bit set.
  - grant != 0 exactly when busy=1.
  - When busy=1, grant[sel]=1.
  - sel is never 7.

Test Plan:
1. Reset, then req=7'b0000001 held, then dropped:
   - Reset gives grant=0, sel=0, busy=0.
   - 1 cycle after req, grant=0000001, sel=0, busy=1, hold_cnt=1.
   - 1 cycle after req drops, grant=0, busy=0.
2. Rotation, req=7'b1111111 held, each grantee drops its req after 2 grant cycles:
   - Grant order is 0,1,2,3,4,5,6,0.
   - One idle cycle between consecutive grants.
3. Wrap priority, with last=5 after a grant to lane 5 ends, then req=7'b0100001:
   - Grant goes to lane 0 (search order 6,0,1,...; lane 6 not requesting).
   - With req=7'b1000001 instead, grant goes to lane 6.
4. Preemption with MAX_HOLD=8, req[2] held forever, req[4] raised at grant cycle 3:
   - Grant to lane 2 releases at the edge where hold_cnt=8.
   - Next cycle is IDLE.
   - Following edge: grant=0010000, sel=4.
5. Sole holder, req=7'b0001000 held for 20 cycles:
   - Lane 3 stays granted for all 20 cycles.
   - hold_cnt saturates at 15 with HOLD_W=4.
6. Reset mid-operation, resetn=0 asserted for one cycle during a lane-5 grant:
   - At that edge: grant=0, busy=0, sel=0.
   - With req=7'b0100001 still high after reset, lane 0 is granted next (last=6).
